regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised successor to the single-write register file: N registers of W bits, two combinational read ports, two write ports (A: ALU writeback, B: memory/multicycle writeback).
- Optional write-to-read bypass and a per-register busy scoreboard, so the pipeline can stall on pending results.
- Sits in the decode stage of the CPU datapath; decode reads operands and ready flags, both writeback stages write.

Parameters:
- W, 32, register width in bits.
- NREG, 32, number of registers; any value 2..64.
- AW, $clog2(NREG), address width; derived, not overridden.
- ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes, is never busy.
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching reads.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- rd1_addr, rd2_addr  in  AW  read addresses.
- rd1_data, rd2_data  out  W  read data, combinational.
- rd1_ready, rd2_ready  out  1  operand valid (not pending), combinational.
- wa_en  in  1  write port A enable.
- wa_addr  in  AW  write port A address.
- wa_data  in  W  write port A data.
- wb_en  in  1  write port B enable.
- wb_addr  in  AW  write port B address.
- wb_data  in  W  write port B data.
- issue_en  in  1  mark a destination as pending.
- issue_addr  in  AW  destination register being issued.
- busy_vec  out  NREG  current scoreboard bits, registered.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset: asserting reset immediately clears every register and every busy bit to 0, mid-cycle included; rdN_data reads 0 and rdN_ready reads 1 during and after reset; busy_vec = 0.
- Writes: registered at posedge clk. A port writes when its enable is high and its address is < NREG, and, when ZERO_REG=1, its address is != 0.
- Write collision: wa and wb on the same address in the same cycle → port B data is stored.
- Reads: combinational.
  - Address >= NREG → 0.
  - Address 0 with ZERO_REG=1 → 0.
  - Otherwise the stored value.
- Bypass (BYPASS=1): if a valid write this cycle targets rdN_addr, rdN_data = that write data, with port B taking priority over A. Zero-latency read-after-write. BYPASS=0 → the new value is visible the cycle after the write.
- Scoreboard, per-address update at posedge, in priority order:
  1. issue_en to address X sets busy[X], even if a write to X occurs in the same cycle (the new producer wins).
  2. Otherwise a valid write (port A or B) to X clears busy[X].
  3. Otherwise busy[X] holds.
- busy[0] is always 0 when ZERO_REG=1. issue_addr >= NREG is ignored.
- Ready: rdN_ready = !busy[rdN_addr], or 1 when BYPASS=1 and a valid write to rdN_addr occurs this cycle. Address out of range or zero-register → 1.
- Re-issue of an already-busy register: it stays busy; no error flag.
- Latency: read 0 cycles; write visibility 1 cycle (0 with bypass); busy set/clear visible on the cycle after the edge.

Decomposition:
- Shared package `regfile_pkg`: default W/NREG constants, a function computing AW, and a register-0 index constant.
- One natural sub-module, `regfile_rdport`: read mux, zero/range masking, bypass priority and ready logic. Instantiated twice.
- Storage and scoreboard stay in the top module.

Test Plan:
- Reset then read: assert reset, write 0xDEADBEEF to r5 while reset is high → rd1(r5) = 0, ready = 1, busy_vec = 0 after release.
- Basic write/read: wa writes r3 = 0x12345678 → rd1(r3) = 0x12345678 on the next cycle; wa to r0 = 0xFFFFFFFF → rd2(r0) stays 0.
- Collision and bypass: wa r7 = 0x1, wb r7 = 0x2 in the same cycle → rd1(r7) = 0x2 in that cycle (bypass) and after the edge. BYPASS=0 build → old value in the cycle, 0x2 after.
- Scoreboard: issue r9 → next cycle rd1_ready(r9) = 0, busy_vec[9] = 1. wb r9 = 0xAA → ready = 1 in the write cycle (bypass), busy_vec[9] = 0 after the edge.
- Issue-vs-write race: with r4 busy, issue r4 and wa r4 = 0x55 in the same cycle → r4 = 0x55 and busy[4] = 1 afterwards.
- Asynchronous reset mid-operation: busy r2, r6 and stored data, pulse reset between edges → all outputs cleared immediately without a clock edge; NREG=24 build: access to r30 reads 0, its write and issue are ignored.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and helpers for the multi-port register file:
//   DEFAULT_W / DEFAULT_NREG : default register width and register count
//   REG0                     : index of the hard-wired zero register
//   calc_aw()                : address width for a given register count
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DEFAULT_W    = 32;
    localparam int DEFAULT_NREG = 32;
    localparam int REG0         = 0;

    // Address width for nreg registers. There is always at least one bit,
    // so that NREG=2 still has a usable address bus.
    function automatic int calc_aw(input int nreg);
        int aw;
        if (nreg > 2) begin
            aw = $clog2(nreg);
        end else begin
            aw = 1;
        end
        return aw;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// -----------------------------------------------------------------------------
// regfile_mp_if
// Bus between the decode/writeback stages (master) and the register file
// (slave).
//   rd1/rd2   : read address in, data and ready flag out (combinational)
//   wa / wb   : write ports A (ALU) and B (memory/multicycle)
//   issue     : marks a destination register as pending
//   busy_vec  : registered scoreboard bits
// -----------------------------------------------------------------------------
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int W    = DEFAULT_W,
    parameter int NREG = DEFAULT_NREG
) ();

    localparam int AW = calc_aw(NREG);

    logic [AW-1:0]   rd1_addr;
    logic [AW-1:0]   rd2_addr;
    logic [W-1:0]    rd1_data;
    logic [W-1:0]    rd2_data;
    logic            rd1_ready;
    logic            rd2_ready;
    logic            wa_en;
    logic [AW-1:0]   wa_addr;
    logic [W-1:0]    wa_data;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [W-1:0]    wb_data;
    logic            issue_en;
    logic [AW-1:0]   issue_addr;
    logic [NREG-1:0] busy_vec;

    modport master (
        output rd1_addr, rd2_addr,
        output wa_en, wa_addr, wa_data,
        output wb_en, wb_addr, wb_data,
        output issue_en, issue_addr,
        input  rd1_data, rd2_data, rd1_ready, rd2_ready, busy_vec
    );

    modport slave (
        input  rd1_addr, rd2_addr,
        input  wa_en, wa_addr, wa_data,
        input  wb_en, wb_addr, wb_data,
        input  issue_en, issue_addr,
        output rd1_data, rd2_data, rd1_ready, rd2_ready, busy_vec
    );

endinterface

// File: rtl/regfile_mp_rdport.sv
// -----------------------------------------------------------------------------
// regfile_rdport
// One combinational read port of the register file.
//   rd_addr_i            : register being read
//   regs_i / busy_i      : stored values and scoreboard bits
//   wa_* / wb_*          : this cycle's already-qualified writes (for bypass)
//   rd_data_o            : operand value
//   rd_ready_o           : operand is not waiting on a pending producer
// -----------------------------------------------------------------------------
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int   W        = DEFAULT_W,
    parameter int   NREG     = DEFAULT_NREG,
    parameter bit   ZERO_REG = 1'b1,
    parameter bit   BYPASS   = 1'b1,
    localparam int  AW       = calc_aw(NREG)
) (
    input  logic [AW-1:0]   rd_addr_i,
    input  logic [W-1:0]    regs_i [NREG],
    input  logic [NREG-1:0] busy_i,
    input  logic            wa_ok_i,
    input  logic [AW-1:0]   wa_addr_i,
    input  logic [W-1:0]    wa_data_i,
    input  logic            wb_ok_i,
    input  logic [AW-1:0]   wb_addr_i,
    input  logic [W-1:0]    wb_data_i,
    output logic [W-1:0]    rd_data_o,
    output logic            rd_ready_o
);

    localparam logic [AW:0] NREG_C = (AW+1)'(NREG);

    logic in_range_s;
    logic is_zero_s;
    logic wa_hit_s;
    logic wb_hit_s;

    assign in_range_s = ({1'b0, rd_addr_i} < NREG_C);
    assign is_zero_s  = ZERO_REG && (rd_addr_i == AW'(REG0));
    // The *_ok inputs are already gated by range, zero register and reset.
    assign wa_hit_s   = BYPASS && wa_ok_i && (wa_addr_i == rd_addr_i);
    assign wb_hit_s   = BYPASS && wb_ok_i && (wb_addr_i == rd_addr_i);

    // Read mux: masking first, then bypass (B over A), then storage.
    always_comb begin
        rd_data_o  = {W{1'b0}};
        rd_ready_o = 1'b1;
        if (!in_range_s || is_zero_s) begin
            rd_data_o  = {W{1'b0}};
            rd_ready_o = 1'b1;
        end else if (wb_hit_s) begin
            rd_data_o  = wb_data_i;
            rd_ready_o = 1'b1;
        end else if (wa_hit_s) begin
            rd_data_o  = wa_data_i;
            rd_ready_o = 1'b1;
        end else begin
            rd_data_o  = regs_i[rd_addr_i];
            rd_ready_o = !busy_i[rd_addr_i];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Register file with two combinational read ports, two write ports and a
// per-register busy scoreboard for pipeline stall decisions.
//   clk   : rising-edge clock for storage and scoreboard
//   reset : asynchronous, active-high; clears storage and scoreboard
//   bus   : regfile_mp_if slave (reads, writes A/B, issue, busy_vec)
// -----------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int W        = DEFAULT_W,
    parameter int NREG     = DEFAULT_NREG,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    regfile_mp_if.slave   bus
);

    localparam int          AW     = calc_aw(NREG);
    localparam logic [AW:0] NREG_C = (AW+1)'(NREG);

    logic [W-1:0]    regs_q [NREG];
    logic [W-1:0]    regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            wa_ok_s;
    logic            wb_ok_s;
    logic            issue_ok_s;

    // An address is writable/issuable if it exists and is not the zero reg.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < NREG_C) && !(ZERO_REG && (a == AW'(REG0)));
    endfunction

    // Reset also blocks bypass, so reads show 0 while reset is held.
    assign wa_ok_s    = bus.wa_en    && addr_ok(bus.wa_addr)    && !reset;
    assign wb_ok_s    = bus.wb_en    && addr_ok(bus.wb_addr)    && !reset;
    assign issue_ok_s = bus.issue_en && addr_ok(bus.issue_addr) && !reset;

    // Next state: port B wins write collisions; issue beats write-clear.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int i = 0; i < NREG; i++) begin
            if (wb_ok_s && (bus.wb_addr == AW'(i))) begin
                regs_d[i] = bus.wb_data;
            end else if (wa_ok_s && (bus.wa_addr == AW'(i))) begin
                regs_d[i] = bus.wa_data;
            end else begin
                regs_d[i] = regs_q[i];
            end

            if (issue_ok_s && (bus.issue_addr == AW'(i))) begin
                busy_d[i] = 1'b1;
            end else if ((wa_ok_s && (bus.wa_addr == AW'(i))) ||
                         (wb_ok_s && (bus.wb_addr == AW'(i)))) begin
                busy_d[i] = 1'b0;
            end else begin
                busy_d[i] = busy_q[i];
            end
        end
    end

    // Storage and scoreboard registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= {W{1'b0}};
            end
            busy_q <= {NREG{1'b0}};
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign bus.busy_vec = busy_q;

    regfile_rdport #(
        .W(W), .NREG(NREG), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rd1 (
        .rd_addr_i (bus.rd1_addr),
        .regs_i    (regs_q),
        .busy_i    (busy_q),
        .wa_ok_i   (wa_ok_s),
        .wa_addr_i (bus.wa_addr),
        .wa_data_i (bus.wa_data),
        .wb_ok_i   (wb_ok_s),
        .wb_addr_i (bus.wb_addr),
        .wb_data_i (bus.wb_data),
        .rd_data_o (bus.rd1_data),
        .rd_ready_o(bus.rd1_ready)
    );

    regfile_rdport #(
        .W(W), .NREG(NREG), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rd2 (
        .rd_addr_i (bus.rd2_addr),
        .regs_i    (regs_q),
        .busy_i    (busy_q),
        .wa_ok_i   (wa_ok_s),
        .wa_addr_i (bus.wa_addr),
        .wa_data_i (bus.wa_data),
        .wb_ok_i   (wb_ok_s),
        .wb_addr_i (bus.wb_addr),
        .wb_data_i (bus.wb_data),
        .rd_data_o (bus.rd2_data),
        .rd_ready_o(bus.rd2_ready)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Three register files share one stimulus: the default build, a BYPASS=0
// build and an NREG=24 build. Inputs change on the falling edge; expected
// values are queued with the stimulus and compared 2 ns later.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    logic        clk;
    logic        reset;
    logic        wa_en, wb_en, iss_en;
    logic [4:0]  wa_addr, wb_addr, iss_addr, rd1, rd2;
    logic [31:0] wa_data, wb_data;

    regfile_mp_if #(.W(32), .NREG(32)) bus_m ();
    regfile_mp_if #(.W(32), .NREG(32)) bus_nb ();
    regfile_mp_if #(.W(32), .NREG(24)) bus_24 ();

    assign bus_m.rd1_addr = rd1;   assign bus_m.rd2_addr = rd2;
    assign bus_m.wa_en = wa_en;    assign bus_m.wa_addr = wa_addr;   assign bus_m.wa_data = wa_data;
    assign bus_m.wb_en = wb_en;    assign bus_m.wb_addr = wb_addr;   assign bus_m.wb_data = wb_data;
    assign bus_m.issue_en = iss_en; assign bus_m.issue_addr = iss_addr;

    assign bus_nb.rd1_addr = rd1;  assign bus_nb.rd2_addr = rd2;
    assign bus_nb.wa_en = wa_en;   assign bus_nb.wa_addr = wa_addr;  assign bus_nb.wa_data = wa_data;
    assign bus_nb.wb_en = wb_en;   assign bus_nb.wb_addr = wb_addr;  assign bus_nb.wb_data = wb_data;
    assign bus_nb.issue_en = iss_en; assign bus_nb.issue_addr = iss_addr;

    assign bus_24.rd1_addr = rd1;  assign bus_24.rd2_addr = rd2;
    assign bus_24.wa_en = wa_en;   assign bus_24.wa_addr = wa_addr;  assign bus_24.wa_data = wa_data;
    assign bus_24.wb_en = wb_en;   assign bus_24.wb_addr = wb_addr;  assign bus_24.wb_data = wb_data;
    assign bus_24.issue_en = iss_en; assign bus_24.issue_addr = iss_addr;

    regfile_mp #(.W(32), .NREG(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_m (
        .clk(clk), .reset(reset), .bus(bus_m.slave));
    regfile_mp #(.W(32), .NREG(32), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .bus(bus_nb.slave));
    regfile_mp #(.W(32), .NREG(24), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_24 (
        .clk(clk), .reset(reset), .bus(bus_24.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output selectors for the scoreboard.
    localparam int M_D1 = 0, M_R1 = 1, M_D2 = 2, M_R2 = 3, M_BUSY = 4;
    localparam int NB_D1 = 5, NB_R1 = 6, S_D1 = 7, S_R1 = 8, S_BUSY = 9;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t sb[$];
    int   passed = 0;
    int   total  = 0;

    typedef struct {
        logic        wa_en;  logic [4:0] wa_addr; logic [31:0] wa_data;
        logic        wb_en;  logic [4:0] wb_addr; logic [31:0] wb_data;
        logic        iss_en; logic [4:0] iss_addr;
        logic [4:0]  rd1;    logic [4:0] rd2;
        logic [31:0] e_d1;   logic e_r1;
        logic [31:0] e_d2;   logic e_r2;
        logic [31:0] e_busy;
        logic [31:0] e_nb_d1; logic e_nb_r1;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [31:0] actual(input int sel);
        logic [31:0] v;
        case (sel)
            M_D1:    v = bus_m.rd1_data;
            M_R1:    v = {31'd0, bus_m.rd1_ready};
            M_D2:    v = bus_m.rd2_data;
            M_R2:    v = {31'd0, bus_m.rd2_ready};
            M_BUSY:  v = bus_m.busy_vec;
            NB_D1:   v = bus_nb.rd1_data;
            NB_R1:   v = {31'd0, bus_nb.rd1_ready};
            S_D1:    v = bus_24.rd1_data;
            S_R1:    v = {31'd0, bus_24.rd1_ready};
            S_BUSY:  v = {8'd0, bus_24.busy_vec};
            default: v = 32'hxxxx_xxxx;
        endcase
        return v;
    endfunction

    task automatic push(input string name, input int sel, input logic [31:0] exp);
        chk_t c;
        c.name = name; c.sel = sel; c.exp = exp;
        sb.push_back(c);
    endtask

    task automatic drain();
        chk_t c;
        logic [31:0] a;
        while (sb.size() > 0) begin
            c = sb.pop_front();
            a = actual(c.sel);
            total++;
            if (a === c.exp) begin
                passed++;
            end else begin
                $display("FAIL %s: got %h, expected %h (t=%0t)", c.name, a, c.exp, $time);
            end
        end
    endtask

    task automatic idle();
        wa_en = 1'b0; wa_addr = 5'd0; wa_data = 32'd0;
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        iss_en = 1'b0; iss_addr = 5'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, iss_en, iss_addr, rd1, rd2,
        // e_d1, e_r1, e_d2, e_r2, e_busy, e_nb_d1, e_nb_r1
        vecs[0]  = '{1'b1, 5'd3, 32'h1234_5678, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0,
                     32'h1234_5678, 1'b1, 32'h0, 1'b1, 32'h0, 32'h0, 1'b1};
        vecs[1]  = '{1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0,
                     32'h1234_5678, 1'b1, 32'h0, 1'b1, 32'h0, 32'h1234_5678, 1'b1};
        vecs[2]  = '{1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, 1'b0, 5'd0, 5'd7, 5'd0,
                     32'h2, 1'b1, 32'h0, 1'b1, 32'h0, 32'h0, 1'b1};
        vecs[3]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd3,
                     32'h2, 1'b1, 32'h1234_5678, 1'b1, 32'h0, 32'h2, 1'b1};
        vecs[4]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd7,
                     32'h0, 1'b1, 32'h2, 1'b1, 32'h0, 32'h0, 1'b1};
        vecs[5]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd3,
                     32'h0, 1'b0, 32'h1234_5678, 1'b1, 32'h200, 32'h0, 1'b0};
        vecs[6]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hAA, 1'b0, 5'd0, 5'd9, 5'd9,
                     32'hAA, 1'b1, 32'hAA, 1'b1, 32'h200, 32'h0, 1'b0};
        vecs[7]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0,
                     32'hAA, 1'b1, 32'h0, 1'b1, 32'h0, 32'hAA, 1'b1};
        vecs[8]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd9,
                     32'h0, 1'b1, 32'hAA, 1'b1, 32'h0, 32'h0, 1'b1};
        vecs[9]  = '{1'b1, 5'd4, 32'h55, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd2,
                     32'h55, 1'b1, 32'h0, 1'b1, 32'h10, 32'h0, 1'b0};
        vecs[10] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd9,
                     32'h55, 1'b0, 32'hAA, 1'b1, 32'h10, 32'h55, 1'b0};
        vecs[11] = '{1'b1, 5'd4, 32'h66, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd4, 5'd0,
                     32'h66, 1'b1, 32'h0, 1'b1, 32'h10, 32'h55, 1'b0};
        vecs[12] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 5'd0, 5'd4,
                     32'h0, 1'b1, 32'h66, 1'b1, 32'h0, 32'h0, 1'b1};
        vecs[13] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h5555, 1'b1, 5'd6, 5'd2, 5'd5,
                     32'h0, 1'b0, 32'h5555, 1'b1, 32'h4, 32'h0, 1'b0};

        reset = 1'b1;
        idle();
        rd1 = 5'd0; rd2 = 5'd0;

        // Write during reset must neither store nor bypass.
        @(negedge clk);
        wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEAD_BEEF; rd1 = 5'd5;
        push("rst_wr_d1", M_D1, 32'h0);
        push("rst_wr_r1", M_R1, 32'h1);
        push("rst_wr_busy", M_BUSY, 32'h0);
        push("rst_wr_nb_d1", NB_D1, 32'h0);
        push("rst_wr_s_d1", S_D1, 32'h0);
        #2 drain();

        @(negedge clk);
        reset = 1'b0;
        idle();
        push("post_rst_d1", M_D1, 32'h0);
        push("post_rst_r1", M_R1, 32'h1);
        push("post_rst_busy", M_BUSY, 32'h0);
        #2 drain();

        // Table-driven main sequence.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            wa_en = vecs[i].wa_en;   wa_addr = vecs[i].wa_addr; wa_data = vecs[i].wa_data;
            wb_en = vecs[i].wb_en;   wb_addr = vecs[i].wb_addr; wb_data = vecs[i].wb_data;
            iss_en = vecs[i].iss_en; iss_addr = vecs[i].iss_addr;
            rd1 = vecs[i].rd1;       rd2 = vecs[i].rd2;
            push($sformatf("v%0d_d1", i), M_D1, vecs[i].e_d1);
            push($sformatf("v%0d_r1", i), M_R1, {31'd0, vecs[i].e_r1});
            push($sformatf("v%0d_d2", i), M_D2, vecs[i].e_d2);
            push($sformatf("v%0d_r2", i), M_R2, {31'd0, vecs[i].e_r2});
            push($sformatf("v%0d_busy", i), M_BUSY, vecs[i].e_busy);
            push($sformatf("v%0d_nb_d1", i), NB_D1, vecs[i].e_nb_d1);
            push($sformatf("v%0d_nb_r1", i), NB_R1, {31'd0, vecs[i].e_nb_r1});
            // All table reads are below 24, so the small build must agree.
            push($sformatf("v%0d_s_d1", i), S_D1, vecs[i].e_d1);
            push($sformatf("v%0d_s_r1", i), S_R1, {31'd0, vecs[i].e_r1});
            push($sformatf("v%0d_s_busy", i), S_BUSY, {8'd0, vecs[i].e_busy[23:0]});
            #2 drain();
        end

        // Asynchronous reset between edges with r2/r6 busy and r5 = 0x5555.
        @(negedge clk);
        idle();
        rd1 = 5'd2; rd2 = 5'd5;
        push("pre_arst_d1", M_D1, 32'h0);
        push("pre_arst_r1", M_R1, 32'h0);
        push("pre_arst_d2", M_D2, 32'h5555);
        push("pre_arst_busy", M_BUSY, 32'h44);
        push("pre_arst_nb_r1", NB_R1, 32'h0);
        #2 drain();
        #1 reset = 1'b1;
        push("arst_d1", M_D1, 32'h0);
        push("arst_r1", M_R1, 32'h1);
        push("arst_d2", M_D2, 32'h0);
        push("arst_r2", M_R2, 32'h1);
        push("arst_busy", M_BUSY, 32'h0);
        push("arst_nb_r1", NB_R1, 32'h1);
        push("arst_s_busy", S_BUSY, 32'h0);
        #1 drain();

        // r30: real register in the 32 build, out of range in the 24 build.
        @(negedge clk);
        reset = 1'b0;
        wa_en = 1'b1; wa_addr = 5'd30; wa_data = 32'hCAFE;
        iss_en = 1'b1; iss_addr = 5'd30;
        rd1 = 5'd30; rd2 = 5'd30;
        push("r30_wr_d1", M_D1, 32'hCAFE);
        push("r30_wr_r1", M_R1, 32'h1);
        push("r30_wr_nb_d1", NB_D1, 32'h0);
        push("r30_wr_s_d1", S_D1, 32'h0);
        push("r30_wr_s_r1", S_R1, 32'h1);
        #2 drain();

        @(negedge clk);
        idle();
        push("r30_d1", M_D1, 32'hCAFE);
        push("r30_r1", M_R1, 32'h0);
        push("r30_busy", M_BUSY, 32'h4000_0000);
        push("r30_nb_d1", NB_D1, 32'hCAFE);
        push("r30_nb_r1", NB_R1, 32'h0);
        push("r30_s_d1", S_D1, 32'h0);
        push("r30_s_r1", S_R1, 32'h1);
        push("r30_s_busy", S_BUSY, 32'h0);
        #2 drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
